// File: rtl/heatwatch_pkg.sv
// Shared types and defaults for the heat alert monitor.
// Optional feature macro used by heat_alert_monitor: HEAT_ALERT_LATCH_EN.
package heatwatch_pkg;

   localparam int DATA_W       = 11;
   localparam int WARN_TH_DEF  = 600;
   localparam int ALERT_TH_DEF = 800;
   localparam int HYST_DEF     = 32;
   localparam int PERSIST_DEF  = 4;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'b00,
      ST_WARN   = 2'b01,
      ST_ALERT  = 2'b10,
      ST_COOL   = 2'b11
   } heat_state_e;

   // Exit level = threshold minus hysteresis, clamped at zero.
   function automatic int exit_level(input int th, input int hyst);
      if (th > hyst) begin
         return th - hyst;
      end else begin
         return 0;
      end
   endfunction

endpackage

// File: rtl/persist_counter.sv
// Counts consecutive qualifying samples; done flags the sample that completes the run.
module persist_counter #(
   parameter int PERSIST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic hit,
   input  logic clear,
   output logic done
);

   localparam int CNT_W = $clog2(PERSIST + 1);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(PERSIST);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PERSIST - 1);

   logic [CNT_W-1:0] cnt_r;

   // done is combinational so the owner can act on the qualifying sample itself.
   assign done = enable & hit & (cnt_r >= LAST_C);

   // Run-length counter: clears on a miss or a state change, saturates at PERSIST.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (enable) begin
         if (!hit) begin
            cnt_r <= '0;
         end else if (cnt_r != MAX_C) begin
            cnt_r <= cnt_r + 1'b1;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/heat_alert_monitor.sv
// Temperature alarm FSM with hysteresis, persistence, peak capture and alert counting.
// Define HEAT_ALERT_LATCH_EN to latch ALERT until an operator ack.
module heat_alert_monitor
   import heatwatch_pkg::*;
#(
   parameter int DATA_W   = heatwatch_pkg::DATA_W,
   parameter int WARN_TH  = heatwatch_pkg::WARN_TH_DEF,
   parameter int ALERT_TH = heatwatch_pkg::ALERT_TH_DEF,
   parameter int HYST     = heatwatch_pkg::HYST_DEF,
   parameter int PERSIST  = heatwatch_pkg::PERSIST_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              ack,
   output logic [1:0]        state_out,
   output logic              warn,
   output logic              alert,
   output logic [DATA_W-1:0] peak_out,
   output logic [7:0]        alert_count
);

   // One extra bit keeps thresholds and exit levels unambiguous at any DATA_W.
   localparam int LW = DATA_W + 1;
   localparam logic [LW-1:0] WARN_LVL_C   = LW'(WARN_TH);
   localparam logic [LW-1:0] ALERT_LVL_C  = LW'(ALERT_TH);
   localparam logic [LW-1:0] WARN_EXIT_C  = LW'(exit_level(WARN_TH, HYST));
   localparam logic [LW-1:0] ALERT_EXIT_C = LW'(exit_level(ALERT_TH, HYST));

   heat_state_e       state_r;
   heat_state_e       next_state_s;
   logic              warn_r;
   logic              alert_r;
   logic [DATA_W-1:0] peak_r;
   logic [7:0]        alert_count_r;

   logic [LW-1:0]     sample_ext_s;
   logic              above_warn_s;
   logic              above_alert_s;
   logic              below_warn_exit_s;
   logic              below_alert_exit_s;
   logic              hit_s;
   logic              done_s;
   logic              change_s;

   assign sample_ext_s       = {1'b0, sample_in};
   assign above_warn_s       = (sample_ext_s >= WARN_LVL_C);
   assign above_alert_s      = (sample_ext_s >= ALERT_LVL_C);
   assign below_warn_exit_s  = (sample_ext_s < WARN_EXIT_C);
   assign below_alert_exit_s = (sample_ext_s < ALERT_EXIT_C);

`ifdef HEAT_ALERT_LATCH_EN
   logic last_below_r;
   logic below_recent_s;
   // An ack without a fresh sample judges the last valid sample seen.
   assign below_recent_s = sample_valid ? below_alert_exit_s : last_below_r;
`endif

   // Condition the persistence counter is accumulating in the current state.
   always_comb begin
      hit_s = 1'b0;
      case (state_r)
         ST_NORMAL: hit_s = above_warn_s;
         ST_WARN:   hit_s = above_alert_s;
         ST_COOL:   hit_s = below_warn_exit_s;
         ST_ALERT:  hit_s = 1'b0;
         default:   hit_s = 1'b0;
      endcase
   end

   // Next-state decision; only qualified samples (or ack when latched) move the FSM.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_NORMAL: begin
            if (done_s) begin
               next_state_s = ST_WARN;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_WARN: begin
            if (sample_valid && below_warn_exit_s) begin
               next_state_s = ST_NORMAL;
            end else if (done_s) begin
               next_state_s = ST_ALERT;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_ALERT: begin
`ifdef HEAT_ALERT_LATCH_EN
            if (ack && below_recent_s) begin
`else
            if (sample_valid && below_alert_exit_s) begin
`endif
               next_state_s = ST_COOL;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_COOL: begin
            if (sample_valid && above_alert_s) begin
               next_state_s = ST_ALERT;
            end else if (done_s) begin
               next_state_s = ST_NORMAL;
            end else begin
               next_state_s = state_r;
            end
         end
         default: next_state_s = ST_NORMAL;
      endcase
   end

   assign change_s = (next_state_s != state_r);

   persist_counter #(
      .PERSIST (PERSIST)
   ) u_persist (
      .clk    (clk),
      .reset  (reset),
      .enable (sample_valid),
      .hit    (hit_s),
      .clear  (change_s),
      .done   (done_s)
   );

   // State, decoded flags, alert counter and peak tracker, all registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_NORMAL;
         warn_r        <= 1'b0;
         alert_r       <= 1'b0;
         peak_r        <= '0;
         alert_count_r <= 8'd0;
      end else begin
         state_r <= next_state_s;
         warn_r  <= (next_state_s == ST_WARN);
         alert_r <= (next_state_s == ST_ALERT);
         if ((next_state_s == ST_ALERT) && (state_r != ST_ALERT) && (alert_count_r != 8'hFF)) begin
            alert_count_r <= alert_count_r + 8'd1;
         end else begin
            alert_count_r <= alert_count_r;
         end
         if (ack) begin
            peak_r <= sample_valid ? sample_in : '0;
         end else if (sample_valid && (sample_in > peak_r)) begin
            peak_r <= sample_in;
         end else begin
            peak_r <= peak_r;
         end
      end
   end

`ifdef HEAT_ALERT_LATCH_EN
   // Remembers whether the last valid sample was below the alert exit level.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_below_r <= 1'b0;
      end else if (sample_valid) begin
         last_below_r <= below_alert_exit_s;
      end else begin
         last_below_r <= last_below_r;
      end
   end
`endif

   assign state_out   = state_r;
   assign warn        = warn_r;
   assign alert       = alert_r;
   assign peak_out    = peak_r;
   assign alert_count = alert_count_r;

endmodule

// File: tb/tb_heat_alert_monitor.sv
// Directed self-checking bench for heat_alert_monitor at default parameters.
module tb_heat_alert_monitor;

   logic        clk;
   logic        reset;
   logic [10:0] sample_in;
   logic        sample_valid;
   logic        ack;
   logic [1:0]  state_out;
   logic        warn;
   logic        alert;
   logic [10:0] peak_out;
   logic [7:0]  alert_count;

   int n_checks;
   int n_fail;

   heat_alert_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .ack          (ack),
      .state_out    (state_out),
      .warn         (warn),
      .alert        (alert),
      .peak_out     (peak_out),
      .alert_count  (alert_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; outputs are stable 1 time unit after the edge.
   task automatic step(input logic [10:0] s, input logic v, input logic a, input logic r);
      @(negedge clk);
      sample_in    = s;
      sample_valid = v;
      ack          = a;
      reset        = r;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      ack          = 1'b0;
      reset        = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Leaves ALERT via a below-exit sample (plus an ack when alerts latch).
   task automatic exit_alert(input logic [10:0] s, input string tag);
      step(s, 1'b1, 1'b0, 1'b0);
`ifdef HEAT_ALERT_LATCH_EN
      chk({tag, "_latched"}, state_out, 32'd2);
      step(11'd0, 1'b0, 1'b1, 1'b0);
`endif
      chk(tag, state_out, 32'd3);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      sample_in    = 11'd0;
      sample_valid = 1'b0;
      ack          = 1'b0;
      reset        = 1'b0;

      // Reset dominates a valid hot sample and ack.
      step(11'd900, 1'b1, 1'b1, 1'b1);
      step(11'd900, 1'b1, 1'b0, 1'b1);
      chk("rst_state", state_out, 32'd0);
      chk("rst_warn", warn, 32'd0);
      chk("rst_alert", alert, 32'd0);
      chk("rst_peak", peak_out, 32'd0);
      chk("rst_count", alert_count, 32'd0);

      // Three hits then a miss: counter restarts, stays NORMAL.
      for (int i = 0; i < 3; i++) step(11'd650, 1'b1, 1'b0, 1'b0);
      step(11'd500, 1'b1, 1'b0, 1'b0);
      chk("miss_state", state_out, 32'd0);
      chk("peak_650", peak_out, 32'd650);
      for (int i = 0; i < 3; i++) step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("restart_3rd", state_out, 32'd0);
      step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("warn_state", state_out, 32'd1);
      chk("warn_flag", warn, 32'd1);
      step(11'd0, 1'b0, 1'b0, 1'b0);
      chk("idle_hold", state_out, 32'd1);

      // WARN -> ALERT; an invalid cycle neither breaks the run nor updates peak.
      step(11'd850, 1'b1, 1'b0, 1'b0);
      step(11'd850, 1'b1, 1'b0, 1'b0);
      step(11'd999, 1'b0, 1'b0, 1'b0);
      step(11'd850, 1'b1, 1'b0, 1'b0);
      chk("warn_3of4", state_out, 32'd1);
      chk("peak_invalid", peak_out, 32'd850);
      step(11'd850, 1'b1, 1'b0, 1'b0);
      chk("alert_state", state_out, 32'd2);
      chk("alert_flag", alert, 32'd1);
      chk("alert_warn0", warn, 32'd0);
      chk("count_1", alert_count, 32'd1);

      // 768 is the exit level: at it stays, below it leaves.
      step(11'd768, 1'b1, 1'b0, 1'b0);
      chk("alert_exit_edge", state_out, 32'd2);
      exit_alert(11'd760, "alert_to_cool");
      chk("cool_alert0", alert, 32'd0);

      // COOL re-enters ALERT on a single hot sample.
      step(11'd810, 1'b1, 1'b0, 1'b0);
      chk("cool_to_alert", state_out, 32'd2);
      chk("count_2", alert_count, 32'd2);
      exit_alert(11'd700, "exit_2");

      // Drive the counter to saturation, then beyond.
      for (int i = 0; i < 253; i++) begin
         step(11'd810, 1'b1, 1'b0, 1'b0);
         exit_alert(11'd700, "loop_exit");
      end
      chk("count_255", alert_count, 32'd255);
      for (int i = 0; i < 3; i++) begin
         step(11'd810, 1'b1, 1'b0, 1'b0);
         exit_alert(11'd700, "sat_exit");
      end
      chk("count_sat", alert_count, 32'd255);

      // COOL -> NORMAL after four samples below 568.
      for (int i = 0; i < 3; i++) step(11'd500, 1'b1, 1'b0, 1'b0);
      chk("cool_3of4", state_out, 32'd3);
      step(11'd500, 1'b1, 1'b0, 1'b0);
      chk("cool_to_normal", state_out, 32'd0);

      // WARN exits on one sample below 568, not at 568.
      for (int i = 0; i < 4; i++) step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("warn_again", state_out, 32'd1);
      step(11'd568, 1'b1, 1'b0, 1'b0);
      chk("warn_exit_edge", state_out, 32'd1);
      step(11'd567, 1'b1, 1'b0, 1'b0);
      chk("warn_to_normal", state_out, 32'd0);
      chk("warn_to_normal_flag", warn, 32'd0);

      // Peak tracking and ack behaviour.
      step(11'd0, 1'b0, 1'b1, 1'b0);
      chk("peak_ack_clear", peak_out, 32'd0);
      step(11'd700, 1'b1, 1'b0, 1'b0);
      chk("peak_700", peak_out, 32'd700);
      step(11'd900, 1'b1, 1'b0, 1'b0);
      step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("peak_900", peak_out, 32'd900);
      step(11'd620, 1'b1, 1'b1, 1'b0);
      chk("peak_ack_valid", peak_out, 32'd620);
      chk("peak_run_warn", state_out, 32'd1);

      // Reset while in ALERT with a valid sample.
      for (int i = 0; i < 4; i++) step(11'd850, 1'b1, 1'b0, 1'b0);
      chk("alert_before_rst", state_out, 32'd2);
      step(11'd900, 1'b1, 1'b0, 1'b1);
      chk("rst2_state", state_out, 32'd0);
      chk("rst2_alert", alert, 32'd0);
      chk("rst2_warn", warn, 32'd0);
      chk("rst2_peak", peak_out, 32'd0);
      chk("rst2_count", alert_count, 32'd0);

      // Reset mid-persistence discards the partial run.
      for (int i = 0; i < 3; i++) step(11'd650, 1'b1, 1'b0, 1'b0);
      step(11'd0, 1'b0, 1'b0, 1'b1);
      step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("rst_partial", state_out, 32'd0);
      for (int i = 0; i < 3; i++) step(11'd650, 1'b1, 1'b0, 1'b0);
      chk("rst_partial_warn", state_out, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
